// File: rtl/status_cnt_pkg.sv
// Shared types and helpers for the status counter bank.
package status_cnt_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2,
    BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  // Register width able to hold 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/status_counter_bank_if.sv
// Lock/mode/clear inputs and counter/running outputs of the status counter bank.
interface status_counter_bank_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 4
);
  logic                      locked;
  logic [CHANNELS*2-1:0]     mode;
  logic [CHANNELS-1:0]       clr;
  logic [CHANNELS*WIDTH-1:0] cnt;
  logic                      running;

  modport master (output locked, mode, clr, input cnt, running);
  modport slave  (input locked, mode, clr, output cnt, running);
endinterface

// File: rtl/status_cnt_channel.sv
// One counter channel: cnt/dir pair advanced on the shared tick according to its mode.
module status_cnt_channel
  import status_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             clr_i,
  input  mode_t            mode_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_t             dir_q, dir_d;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (clr_i) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else begin
      if (mode_i != BOUNCE) dir_d = DIR_UP;
      if (tick_i) begin
        case (mode_i)
          STOP:   cnt_d = cnt_q;
          UP:     cnt_d = cnt_q + CNT_ONE;
          DOWN:   cnt_d = cnt_q - CNT_ONE;
          BOUNCE: begin
            // Endpoints are visited once: turn around instead of repeating them.
            if (dir_q == DIR_UP) begin
              if (cnt_q == CNT_MAX) begin
                cnt_d = CNT_MAX - CNT_ONE;
                dir_d = DIR_DN;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end else begin
              if (cnt_q == '0) begin
                cnt_d = CNT_ONE;
                dir_d = DIR_UP;
              end else begin
                cnt_d = cnt_q - CNT_ONE;
              end
            end
          end
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/status_counter_bank.sv
// Bank of independent status counters paced by a shared prescaler and gated by a
// synchronised, held-off PLL lock.
module status_counter_bank
  import status_cnt_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned LOCK_HOLDOFF = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  status_counter_bank_if.slave bus
);

  localparam int unsigned    PW        = cnt_w(PRESCALE);
  localparam int unsigned    HW        = cnt_w(LOCK_HOLDOFF + 1);
  localparam logic [PW-1:0]  PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LOCK_HOLDOFF);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LOCK_HOLDOFF - 1);

  logic          sync1_q, lock_s_q;
  logic [HW-1:0] hold_q, hold_d;
  logic          running_q, running_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_c;
  logic [CHANNELS*WIDTH-1:0] cnt_all;

  // Hold-off: running once lock_s has been seen for LOCK_HOLDOFF consecutive edges.
  always_comb begin
    hold_d    = '0;
    running_d = 1'b0;
    if (lock_s_q) begin
      hold_d    = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
      running_d = (hold_q >= HOLD_LAST);
    end
  end

  assign tick_c = running_q && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = '0;
    if (running_q && !tick_c) pre_d = pre_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      hold_q    <= '0;
      running_q <= 1'b0;
      pre_q     <= '0;
    end else begin
      sync1_q   <= bus.locked;
      lock_s_q  <= sync1_q;
      hold_q    <= hold_d;
      running_q <= running_d;
      pre_q     <= pre_d;
    end
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    status_cnt_channel #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_i (tick_c),
      .clr_i  (bus.clr[i]),
      .mode_i (mode_t'(bus.mode[2*i +: 2])),
      .cnt_o  (cnt_all[i*WIDTH +: WIDTH])
    );
  end

  assign bus.cnt     = cnt_all;
  assign bus.running = running_q;

endmodule
